// File: rtl/uv_pred_ctrl_pkg.sv
// Shared constants for the chroma intra-predictor scheduler: mode indices,
// one-hot FSM state encoding and the default cost width.
package uv_pred_ctrl_pkg;

  localparam int unsigned COST_W_DEF = 24;

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_TM = 2'd1;
  localparam logic [1:0] MODE_VE = 2'd2;
  localparam logic [1:0] MODE_HE = 2'd3;

  typedef enum logic [5:0] {
    IDLE      = 6'b000001,
    ISSUE     = 6'b000010,
    WAIT_PRED = 6'b000100,
    WAIT_COST = 6'b001000,
    NEXT      = 6'b010000,
    DONE      = 6'b100000
  } state_t;

endpackage

// File: rtl/uv_pred_ctrl_if.sv
// Handshake bundle between the mode-decision stage / predictor datapath
// (master) and the chroma predictor scheduler (slave).
interface uv_pred_ctrl_if #(
  parameter int unsigned BLOCK_NUM = 10,
  parameter int unsigned COST_W    = 24
);
  logic                 mb_start;
  logic [BLOCK_NUM-1:0] mb_x;
  logic [BLOCK_NUM-1:0] mb_y;
  logic [3:0]           mode_mask;
  logic                 pred_done;
  logic                 cost_valid;
  logic [COST_W-1:0]    cost;
  logic                 pred_start;
  logic [1:0]           pred_mode;
  logic [BLOCK_NUM-1:0] pred_x;
  logic [BLOCK_NUM-1:0] pred_y;
  logic                 busy;
  logic                 mb_done;
  logic [1:0]           best_mode;
  logic [COST_W-1:0]    best_cost;
  logic                 err;

  modport master (
    output mb_start, mb_x, mb_y, mode_mask, pred_done, cost_valid, cost,
    input  pred_start, pred_mode, pred_x, pred_y, busy, mb_done,
           best_mode, best_cost, err
  );

  modport slave (
    input  mb_start, mb_x, mb_y, mode_mask, pred_done, cost_valid, cost,
    output pred_start, pred_mode, pred_x, pred_y, busy, mb_done,
           best_mode, best_cost, err
  );
endinterface

// File: rtl/uv_mode_pick.sv
// Combinational next-set-bit finder over the 4-bit mode mask. With incl=1 the
// current index itself qualifies (used for the lowest-set-bit search at capture).
module uv_mode_pick (
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  input  logic       incl,
  output logic [1:0] nxt,
  output logic       found
);
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && mask[i] && ((i > 32'(cur)) || (incl && (i == 32'(cur))))) begin
        nxt   = 2'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uv_pred_ctrl.sv
// Chroma (U/V) intra-predictor scheduler: runs each masked mode, keeps the
// minimum-cost one. Optional macro UV_EDGE_SKIP_EN drops modes lacking neighbours.
module uv_pred_ctrl
  import uv_pred_ctrl_pkg::*;
#(
  parameter int unsigned BLOCK_NUM = 10,
  parameter int unsigned COST_W    = COST_W_DEF,
  parameter int unsigned TIMEOUT   = 64
) (
  input logic           clk,
  input logic           rst_n,
  uv_pred_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t               state;
  logic [3:0]           mask_r;
  logic [1:0]           mode_idx;
  logic [COST_W-1:0]    run_min;
  logic [1:0]           run_idx;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 pred_start_r;
  logic [1:0]           pred_mode_r;
  logic [BLOCK_NUM-1:0] pred_x_r;
  logic [BLOCK_NUM-1:0] pred_y_r;
  logic                 busy_r;
  logic                 mb_done_r;
  logic [1:0]           best_mode_r;
  logic [COST_W-1:0]    best_cost_r;
  logic                 err_r;

  logic [3:0] raw_mask;
  logic [3:0] eff_mask;
  logic [3:0] pick_mask;
  logic [1:0] pick_cur;
  logic       pick_incl;
  logic [1:0] pick_idx;
  logic       pick_found;

  always_comb begin
    raw_mask = bus.mode_mask;
`ifdef UV_EDGE_SKIP_EN
    if (bus.mb_y == '0) begin
      raw_mask[MODE_VE] = 1'b0;
      raw_mask[MODE_TM] = 1'b0;
    end
    if (bus.mb_x == '0) begin
      raw_mask[MODE_HE] = 1'b0;
      raw_mask[MODE_TM] = 1'b0;
    end
`endif
    eff_mask = (raw_mask == '0) ? 4'b0001 : raw_mask;
  end

  // One finder serves both capture (lowest bit, inclusive) and NEXT (strictly higher).
  always_comb begin
    pick_mask = (state == IDLE) ? eff_mask : mask_r;
    pick_cur  = (state == IDLE) ? MODE_DC  : mode_idx;
    pick_incl = (state == IDLE);
  end

  uv_mode_pick u_pick (
    .mask  (pick_mask),
    .cur   (pick_cur),
    .incl  (pick_incl),
    .nxt   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_r       <= '0;
      mode_idx     <= '0;
      run_min      <= '1;
      run_idx      <= '0;
      wait_cnt     <= '0;
      pred_start_r <= 1'b0;
      pred_mode_r  <= '0;
      pred_x_r     <= '0;
      pred_y_r     <= '0;
      busy_r       <= 1'b0;
      mb_done_r    <= 1'b0;
      best_mode_r  <= '0;
      best_cost_r  <= '0;
      err_r        <= 1'b0;
    end else begin
      pred_start_r <= 1'b0;
      mb_done_r    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mb_start) begin
            pred_x_r     <= bus.mb_x;
            pred_y_r     <= bus.mb_y;
            mask_r       <= eff_mask;
            mode_idx     <= pick_idx;
            pred_mode_r  <= pick_idx;
            pred_start_r <= 1'b1;
            run_min      <= '1;
            run_idx      <= MODE_DC;
            err_r        <= 1'b0;
            busy_r       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT_PRED;
        end
        WAIT_PRED: begin
          if (bus.pred_done) begin
            wait_cnt <= '0;
            state    <= WAIT_COST;
          end else if (wait_cnt == CNT_LAST) begin
            err_r <= 1'b1;
            state <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WAIT_COST: begin
          if (bus.cost_valid) begin
            if (bus.cost < run_min) begin
              run_min <= bus.cost;
              run_idx <= mode_idx;
            end
            state <= NEXT;
          end else if (wait_cnt == CNT_LAST) begin
            err_r <= 1'b1;
            state <= NEXT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          if (pick_found) begin
            mode_idx     <= pick_idx;
            pred_mode_r  <= pick_idx;
            pred_start_r <= 1'b1;
            state        <= ISSUE;
          end else begin
            mb_done_r   <= 1'b1;
            best_mode_r <= run_idx;
            best_cost_r <= run_min;
            state       <= DONE;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pred_start = pred_start_r;
  assign bus.pred_mode  = pred_mode_r;
  assign bus.pred_x     = pred_x_r;
  assign bus.pred_y     = pred_y_r;
  assign bus.busy       = busy_r;
  assign bus.mb_done    = mb_done_r;
  assign bus.best_mode  = best_mode_r;
  assign bus.best_cost  = best_cost_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_uv_pred_ctrl.sv
// Directed table-driven bench for uv_pred_ctrl; expectations follow the
// UV_EDGE_SKIP_EN setting of the build.
module tb_uv_pred_ctrl;
  localparam int unsigned BN = 10;
  localparam int unsigned CW = 24;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uv_pred_ctrl_if #(.BLOCK_NUM(BN), .COST_W(CW)) u_if ();

  uv_pred_ctrl #(.BLOCK_NUM(BN), .COST_W(CW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  typedef struct {
    string              name;
    logic [3:0]         mask;
    logic [BN-1:0]      x;
    logic [BN-1:0]      y;
    logic [3:0][CW-1:0] c;
    int                 hang_kind;   // 0 none, 1 no pred_done, 2 no cost_valid
    int                 hang_mode;
    bit                 cv_with_pd;
    bit                 extra_start;
    logic [3:0]         exp_issued;
    logic [1:0]         exp_mode;
    logic [CW-1:0]      exp_cost;
    int                 exp_err_cyc;
    int                 exp_done_cyc;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0]    r_issued;
  bit            r_order_ok;
  int            r_done_cnt, r_done_cyc, r_err_cyc;
  logic [1:0]    r_best_mode;
  logic [CW-1:0] r_best_cost;
  logic          r_busy_at_done;
  logic [BN-1:0] r_x, r_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    u_if.mb_start   = 1'b0;
    u_if.mb_x       = '0;
    u_if.mb_y       = '0;
    u_if.mode_mask  = '0;
    u_if.pred_done  = 1'b0;
    u_if.cost_valid = 1'b0;
    u_if.cost       = '0;
  endtask

  task automatic run_mb(input vec_t v);
    int         cyc, pd_at, cv_at, last;
    logic [1:0] cur;
    r_issued = '0; r_order_ok = 1'b1; r_done_cnt = 0; r_done_cyc = 0; r_err_cyc = 0;
    r_best_mode = '0; r_best_cost = '0; r_busy_at_done = 1'b0; r_x = '0; r_y = '0;
    last = -1; cur = '0; pd_at = -1; cv_at = -1;
    @(posedge clk); #1;
    u_if.mb_start = 1'b1; u_if.mb_x = v.x; u_if.mb_y = v.y; u_if.mode_mask = v.mask;
    @(posedge clk); #1;
    u_if.mb_start = 1'b0;
    cyc = 1;
    while (cyc < 400) begin
      u_if.pred_done = 1'b0; u_if.cost_valid = 1'b0; u_if.cost = '0; u_if.mb_start = 1'b0;
      if (u_if.err && r_err_cyc == 0) r_err_cyc = cyc;
      if (u_if.mb_done) begin
        r_done_cnt++; r_done_cyc = cyc;
        r_best_mode = u_if.best_mode; r_best_cost = u_if.best_cost;
        r_busy_at_done = u_if.busy; r_x = u_if.pred_x; r_y = u_if.pred_y;
        break;
      end
      if (u_if.pred_start) begin
        cur = u_if.pred_mode;
        if (int'(cur) <= last) r_order_ok = 1'b0;
        last = int'(cur);
        r_issued[cur] = 1'b1;
        pd_at = (v.hang_kind == 1 && int'(cur) == v.hang_mode) ? -1 : cyc + 1;
      end
      if (cyc == pd_at) begin
        u_if.pred_done = 1'b1;
        if (v.cv_with_pd) begin
          u_if.cost_valid = 1'b1;
          u_if.cost = CW'(1);
          cv_at = cyc + 2;
        end else begin
          cv_at = cyc + 1;
        end
        if (v.hang_kind == 2 && int'(cur) == v.hang_mode) cv_at = -1;
      end else if (cyc == cv_at) begin
        u_if.cost_valid = 1'b1;
        u_if.cost = v.c[cur];
      end
      if (v.extra_start && cyc == 2) begin
        u_if.mb_start = 1'b1; u_if.mode_mask = 4'hF; u_if.mb_x = v.x + BN'(1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({v.name, ".issued"},    32'(r_issued),       32'(v.exp_issued));
    chk({v.name, ".order"},     32'(r_order_ok),     32'd1);
    chk({v.name, ".done_cnt"},  32'(r_done_cnt),     32'd1);
    chk({v.name, ".done_cyc"},  32'(r_done_cyc),     32'(v.exp_done_cyc));
    chk({v.name, ".best_mode"}, 32'(r_best_mode),    32'(v.exp_mode));
    chk({v.name, ".best_cost"}, 32'(r_best_cost),    32'(v.exp_cost));
    chk({v.name, ".err_cyc"},   32'(r_err_cyc),      32'(v.exp_err_cyc));
    chk({v.name, ".busy_done"}, 32'(r_busy_at_done), 32'd1);
    chk({v.name, ".pred_x"},    32'(r_x),            32'(v.x));
    chk({v.name, ".pred_y"},    32'(r_y),            32'(v.y));
    @(posedge clk); #1;
    chk({v.name, ".busy_after"}, 32'(u_if.busy),    32'd0);
    chk({v.name, ".done_after"}, 32'(u_if.mb_done), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int done_seen;
    idle_inputs();

    // name, mask, x, y, costs{HE,VE,TM,DC}, hang kind/mode, cv_with_pd, extra_start,
    // issued, best_mode, best_cost, err cycle, mb_done cycle
    vecs[0] = '{"cost_seq", 4'hF, 3, 2, {24'd70, 24'd50, 24'd50, 24'd100}, 0, 0, 0, 0,
                4'hF, 2'd1, 24'd50, 0, 17};
    vecs[1] = '{"zero_mask", 4'h0, 4, 4, {24'd9, 24'd9, 24'd9, 24'd200}, 0, 0, 0, 0,
                4'h1, 2'd0, 24'd200, 0, 5};
`ifdef UV_EDGE_SKIP_EN
    vecs[2] = '{"edge_skip", 4'hF, 0, 0, {24'd10, 24'd20, 24'd30, 24'd40}, 0, 0, 0, 0,
                4'h1, 2'd0, 24'd40, 0, 5};
`else
    vecs[2] = '{"edge_skip", 4'hF, 0, 0, {24'd10, 24'd20, 24'd30, 24'd40}, 0, 0, 0, 0,
                4'hF, 2'd3, 24'd10, 0, 17};
`endif
    vecs[3] = '{"timeout_pred", 4'h3, 1, 1, {24'd0, 24'd0, 24'd30, 24'd5}, 1, 0, 0, 0,
                4'h3, 2'd1, 24'd30, 18, 23};
    vecs[4] = '{"all_timeout", 4'h1, 1, 1, {24'd0, 24'd0, 24'd0, 24'd5}, 1, 0, 0, 0,
                4'h1, 2'd0, 24'hFFFFFF, 18, 19};
    vecs[5] = '{"he_only", 4'h8, 1, 1, {24'd5, 24'd0, 24'd0, 24'd0}, 0, 0, 0, 0,
                4'h8, 2'd3, 24'd5, 0, 5};
    vecs[6] = '{"tm_ve", 4'h6, 2, 2, {24'd0, 24'd8, 24'd9, 24'd0}, 0, 0, 0, 0,
                4'h6, 2'd2, 24'd8, 0, 9};
    vecs[7] = '{"timeout_cost", 4'h5, 2, 3, {24'd0, 24'd3, 24'd0, 24'd77}, 2, 2, 0, 0,
                4'h5, 2'd0, 24'd77, 23, 24};
    vecs[8] = '{"ignored_strobes", 4'h3, 5, 6, {24'd0, 24'd0, 24'd40, 24'd60}, 0, 0, 1, 1,
                4'h3, 2'd1, 24'd40, 0, 11};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy",      32'(u_if.busy),       32'd0);
    chk("reset.pred_start",32'(u_if.pred_start), 32'd0);
    chk("reset.mb_done",   32'(u_if.mb_done),    32'd0);
    chk("reset.outs",      32'({u_if.pred_mode, u_if.pred_x, u_if.pred_y, u_if.best_mode, u_if.err}), 32'd0);
    chk("reset.best_cost", 32'(u_if.best_cost),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_mb(vecs[i]);

    // Reset pulse while the DUT sits in WAIT_COST.
    @(posedge clk); #1;
    u_if.mb_start = 1'b1; u_if.mb_x = 10'd7; u_if.mb_y = 10'd7; u_if.mode_mask = 4'h1;
    @(posedge clk); #1;
    u_if.mb_start = 1'b0;
    @(posedge clk); #1;
    u_if.pred_done = 1'b1;
    @(posedge clk); #1;
    u_if.pred_done = 1'b0;
    chk("rst_mid.busy_before", 32'(u_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.busy",      32'(u_if.busy),      32'd0);
    chk("rst_mid.outs",      32'({u_if.pred_start, u_if.mb_done, u_if.pred_mode, u_if.best_mode, u_if.err}), 32'd0);
    chk("rst_mid.pred_xy",   32'({u_if.pred_x, u_if.pred_y}), 32'd0);
    chk("rst_mid.best_cost", 32'(u_if.best_cost), 32'd0);
    @(posedge clk); #1;
    u_if.cost_valid = 1'b1; u_if.cost = 24'd3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      u_if.cost_valid = 1'b0;
      if (u_if.mb_done || u_if.busy) done_seen++;
    end
    chk("rst_mid.no_done", 32'(done_seen), 32'd0);

    run_mb(vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
